// File: rtl/game_move_sequencer.sv
// rtl/game_move_sequencer.sv - sequences one 2048 move: slide/merge, spawn, win/lose check
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   enable         in   game active; low reloads the board (LFSR keeps running)
//   initial_matrix in   board loaded on rst or ~enable, [row][col] 12-bit tiles
//   dir_valid      in   direction request
//   dir            in   00 up, 01 down, 10 left, 11 right
//   dir_ready      out  high only in IDLE
//   matrix_Q       out  current board register
//   score          out  accumulated merge sum, saturating
//   busy           out  move in progress
//   done           out  one-cycle pulse when a move finishes
//   moved          out  valid with done: slide/merge changed the board
//   win / lose     out  terminal state levels
module game_move_sequencer #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [11:0] WIN_VALUE = 12'd2048
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [3:0][3:0][11:0]  initial_matrix,
  input  logic                   dir_valid,
  input  logic [1:0]             dir,
  output logic                   dir_ready,
  output logic [3:0][3:0][11:0]  matrix_Q,
  output logic [15:0]            score,
  output logic                   busy,
  output logic                   done,
  output logic                   moved,
  output logic                   win,
  output logic                   lose
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_WIN, S_LOSE
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0][3:0][11:0]   board_q, board_d;
  logic [15:0]             score_q, score_d;
  logic [15:0]             lfsr_q, lfsr_next;
  logic [1:0]              line_q, line_d;
  logic [1:0]              dir_q, dir_d;
  logic                    changed_q, changed_d;
  logic                    done_q, done_d;
  logic                    moved_q, moved_d;

  // Line datapath: cell coordinates of the current line in read order.
  logic [3:0][1:0]         rr, cc;
  logic [3:0][11:0]        line_in, line_out;
  logic [4:0][11:0]        comp;
  logic [2:0]              comp_n;
  logic [1:0]              wr_pos;
  logic                    skip;
  logic [12:0]             line_gain;
  logic [16:0]             score_sum;

  logic                    spawn_found;
  logic [3:0]              spawn_idx, scan_idx;
  logic                    any_win, any_empty, any_pair;

  // x^16+x^14+x^13+x^11 Fibonacci form, shifting right.
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    rr = '0;
    cc = '0;
    line_in = '0;
    for (int p = 0; p < 4; p++) begin
      case (dir_q)
        2'b00:   begin rr[p] = 2'(p);     cc[p] = line_q;     end
        2'b01:   begin rr[p] = 2'(3 - p); cc[p] = line_q;     end
        2'b10:   begin rr[p] = line_q;    cc[p] = 2'(p);      end
        default: begin rr[p] = line_q;    cc[p] = 2'(3 - p);  end
      endcase
      line_in[p] = board_q[rr[p]][cc[p]];
    end

    // Compress toward the read start; comp[4] stays zero as a merge sentinel.
    comp   = '0;
    comp_n = '0;
    for (int p = 0; p < 4; p++) begin
      if (line_in[p] != '0) begin
        comp[comp_n] = line_in[p];
        comp_n       = comp_n + 3'd1;
      end
    end

    // Single-pass merge: a merged pair consumes both entries, so the result
    // can never merge again in this move.
    line_out  = '0;
    line_gain = '0;
    wr_pos    = '0;
    skip      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1] && comp[i] < WIN_VALUE) begin
          line_out[wr_pos] = {comp[i][10:0], 1'b0};
          line_gain        = line_gain + {comp[i], 1'b0};
          skip             = 1'b1;
        end else begin
          line_out[wr_pos] = comp[i];
        end
        wr_pos = wr_pos + 2'd1;
      end
    end
  end

  assign score_sum = {1'b0, score_q} + {4'b0, line_gain};

  // First empty cell scanning upward from lfsr[3:0] with wrap.
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = lfsr_q[3:0];
    scan_idx    = '0;
    for (int k = 0; k < 16; k++) begin
      scan_idx = lfsr_q[3:0] + 4'(k);
      if (!spawn_found && board_q[scan_idx[3:2]][scan_idx[1:0]] == '0) begin
        spawn_found = 1'b1;
        spawn_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[r][c] >= WIN_VALUE) any_win = 1'b1;
        if (board_q[r][c] == '0) any_empty = 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
        if (board_q[r][c] == board_q[r][c+1]) any_pair = 1'b1;
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[r][c] == board_q[r+1][c]) any_pair = 1'b1;
      end
    end
  end

  // State register (plus datapath registers that share the reset rule).
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_next;

    if (rst || !enable) begin
      state_q   <= S_IDLE;
      board_q   <= initial_matrix;
      score_q   <= '0;
      line_q    <= '0;
      dir_q     <= '0;
      changed_q <= 1'b0;
      done_q    <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      score_q   <= score_d;
      line_q    <= line_d;
      dir_q     <= dir_d;
      changed_q <= changed_d;
      done_q    <= done_d;
      moved_q   <= moved_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    score_d   = score_q;
    line_d    = line_q;
    dir_d     = dir_q;
    changed_d = changed_q;
    done_d    = 1'b0;
    moved_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dir_valid) begin
          state_d   = S_MOVE;
          dir_d     = dir;
          changed_d = 1'b0;
          line_d    = '0;
        end
      end
      S_MOVE: begin
        for (int p = 0; p < 4; p++) board_d[rr[p]][cc[p]] = line_out[p];
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (line_out != line_in) changed_d = 1'b1;
        line_d = line_q + 2'd1;
        if (line_q == 2'd3) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (changed_q && spawn_found)
          board_d[spawn_idx[3:2]][spawn_idx[1:0]] = (lfsr_q[7:4] == 4'd0) ? 12'd4 : 12'd2;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        done_d  = 1'b1;
        moved_d = changed_q;
        if (any_win)                     state_d = S_WIN;
        else if (!any_empty && !any_pair) state_d = S_LOSE;
        else                             state_d = S_IDLE;
      end
      S_WIN, S_LOSE: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    dir_ready = (state_q == S_IDLE);
    busy      = !(state_q == S_IDLE || state_q == S_WIN || state_q == S_LOSE);
    win       = (state_q == S_WIN);
    lose      = (state_q == S_LOSE);
  end

  assign matrix_Q = board_q;
  assign score    = score_q;
  assign done     = done_q;
  assign moved    = moved_q;

endmodule
